// File: rtl/motor_pkg.sv
// Shared definitions for the drive path: command encodings (shared with the
// UART/Bluetooth receiver), controller state encodings and per-wheel
// direction pin patterns.
// No ports; imported by the interface, pwm_gen and motor_drive_ctrl.
package motor_pkg;

  // Drive command as delivered by the receiver.
  typedef enum logic [1:0] {
    CMD_STOP  = 2'b00,
    CMD_FWD   = 2'b01,
    CMD_LEFT  = 2'b10,
    CMD_RIGHT = 2'b11
  } cmd_e;

  // Controller state, exported on ctrl_state for LEDs/debug.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DEAD = 2'b01,
    ST_RAMP = 2'b10,
    ST_RUN  = 2'b11
  } state_e;

  // Per-wheel bridge pin patterns, ordered {in1, in2}.
  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_COAST = 2'b00;

  // Both wheels' pin patterns for a command, ordered {left, right}.
  function automatic logic [3:0] dir_pattern(input logic [1:0] cmd);
    logic [3:0] pat;
    case (cmd)
      CMD_FWD:   pat = {DIR_FWD, DIR_FWD};
      CMD_LEFT:  pat = {DIR_REV, DIR_FWD};
      CMD_RIGHT: pat = {DIR_FWD, DIR_REV};
      CMD_STOP:  pat = {DIR_COAST, DIR_COAST};
      default:   pat = {DIR_COAST, DIR_COAST};
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/motor_drive_ctrl_if.sv
// Bundle of the drive command and the H-bridge / debug outputs.
//   driver      : 2-bit drive command (receiver -> controller)
//   left_in1/2  : left bridge direction pins
//   right_in1/2 : right bridge direction pins
//   left_en     : left bridge PWM enable
//   right_en    : right bridge PWM enable
//   ctrl_state  : controller state for LEDs/debug
// master = command source side, slave = motor_drive_ctrl side.
interface motor_drive_ctrl_if;
  import motor_pkg::*;

  logic [1:0] driver;
  logic       left_in1;
  logic       left_in2;
  logic       right_in1;
  logic       right_in2;
  logic       left_en;
  logic       right_en;
  logic [1:0] ctrl_state;

  modport master (
    output driver,
    input  left_in1, left_in2, right_in1, right_in2,
    input  left_en, right_en, ctrl_state
  );

  modport slave (
    input  driver,
    output left_in1, left_in2, right_in1, right_in2,
    output left_en, right_en, ctrl_state
  );

endinterface

// File: rtl/motor_drive_ctrl_pwm_gen.sv
// Free-running PWM generator shared by both wheels.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   duty       : requested duty in counter ticks
//   force_zero : drop the shadow duty to 0 immediately (command change)
//   pwm_out    : registered enable, high while counter < shadow duty
// The duty is sampled into a shadow register only when the counter wraps so
// a running period is never cut short or stretched; force_zero overrides
// that so the bridge is disabled on the very next cycle.
module pwm_gen #(
  parameter int PWM_BITS   = 10,
  parameter int PWM_PERIOD = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                force_zero,
  output logic                pwm_out
);

  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(PWM_PERIOD - 1);
  localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1);

  logic [PWM_BITS-1:0] cnt_r;
  logic [PWM_BITS-1:0] cnt_s;
  logic [PWM_BITS-1:0] shadow_r;
  logic [PWM_BITS-1:0] shadow_s;
  logic                wrap_s;
  logic                pwm_r;
  logic                pwm_s;

  // Next counter, shadow and enable values.
  always_comb begin
    wrap_s = (cnt_r == CNT_LAST);
    if (wrap_s) begin
      cnt_s = '0;
    end else begin
      cnt_s = cnt_r + CNT_ONE;
    end
    // Forced zero beats the wrap-time load.
    if (force_zero) begin
      shadow_s = '0;
    end else if (wrap_s) begin
      shadow_s = duty;
    end else begin
      shadow_s = shadow_r;
    end
    // Enable is evaluated on next-state values so the output is registered
    // yet still equals (cnt < shadow) in the same cycle.
    pwm_s = (cnt_s < shadow_s);
  end

  // Counter, shadow and enable registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= '0;
      shadow_r <= '0;
      pwm_r    <= 1'b0;
    end else begin
      cnt_r    <= cnt_s;
      shadow_r <= shadow_s;
      pwm_r    <= pwm_s;
    end
  end

  assign pwm_out = pwm_r;

endmodule

// File: rtl/motor_drive_ctrl.sv
// Dual H-bridge drive controller.
//   clk   : 50 MHz system clock (same domain as the command receiver)
//   rst_n : asynchronous active-low reset
//   bus   : motor_drive_ctrl_if.slave -- driver command in; direction pins,
//           PWM enables and ctrl_state out
// Any command change coasts both wheels for DEAD_CYCLES, then the duty
// soft-starts from 0 toward the command's target in RAMP_STEP increments
// every RAMP_DIV cycles. Direction pins and state are registered from the
// next-state values so they change on the same edge as the state itself.
module motor_drive_ctrl
  import motor_pkg::*;
#(
  parameter int PWM_BITS    = 10,
  parameter int PWM_PERIOD  = 1000,
  parameter int FWD_DUTY    = 800,
  parameter int TURN_DUTY   = 600,
  parameter int RAMP_STEP   = 8,
  parameter int RAMP_DIV    = 5000,
  parameter int DEAD_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  motor_drive_ctrl_if.slave   bus
);

  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
  localparam int RAMP_W = $clog2(RAMP_DIV + 1);

  localparam logic [DEAD_W-1:0]   DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [DEAD_W-1:0]   DEAD_ONE  = DEAD_W'(1);
  localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
  localparam logic [RAMP_W-1:0]   RAMP_ONE  = RAMP_W'(1);
  localparam logic [PWM_BITS-1:0] FWD_D     = PWM_BITS'(FWD_DUTY);
  localparam logic [PWM_BITS-1:0] TURN_D    = PWM_BITS'(TURN_DUTY);
  // One bit wider than the duty so duty + step can never wrap.
  localparam logic [PWM_BITS:0]   STEP_X    = (PWM_BITS + 1)'(RAMP_STEP);

  state_e              state_r;
  state_e              state_s;
  logic [1:0]          active_cmd_r;
  logic [1:0]          active_cmd_s;
  logic [PWM_BITS-1:0] duty_r;
  logic [PWM_BITS-1:0] duty_s;
  logic [DEAD_W-1:0]   dead_cnt_r;
  logic [DEAD_W-1:0]   dead_cnt_s;
  logic [RAMP_W-1:0]   ramp_cnt_r;
  logic [RAMP_W-1:0]   ramp_cnt_s;
  logic [3:0]          dir_r;
  logic [3:0]          dir_s;
  logic [PWM_BITS-1:0] target_s;
  logic [PWM_BITS:0]   duty_sum_s;
  logic                change_s;
  logic                pwm_s;

  // Target duty of the latched command.
  always_comb begin
    target_s = '0;
    case (active_cmd_r)
      CMD_FWD:             target_s = FWD_D;
      CMD_LEFT, CMD_RIGHT: target_s = TURN_D;
      default:             target_s = '0;
    endcase
  end

  // Next-state logic: change detection, dead-time, soft-start ramp.
  always_comb begin
    state_s      = state_r;
    active_cmd_s = active_cmd_r;
    duty_s       = duty_r;
    dead_cnt_s   = dead_cnt_r;
    ramp_cnt_s   = ramp_cnt_r;
    change_s     = (bus.driver != active_cmd_r);
    duty_sum_s   = {1'b0, duty_r} + STEP_X;

    // A change outranks every other event on the same edge.
    if (change_s) begin
      active_cmd_s = bus.driver;
      state_s      = ST_DEAD;
      duty_s       = '0;
      dead_cnt_s   = '0;
      ramp_cnt_s   = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          duty_s = '0;
        end
        ST_DEAD: begin
          if (dead_cnt_r == DEAD_LAST) begin
            ramp_cnt_s = '0;
            if (active_cmd_r == CMD_STOP) begin
              state_s = ST_IDLE;
            end else begin
              state_s = ST_RAMP;
            end
          end else begin
            dead_cnt_s = dead_cnt_r + DEAD_ONE;
          end
        end
        ST_RAMP: begin
          if (ramp_cnt_r == RAMP_LAST) begin
            ramp_cnt_s = '0;
            if (duty_sum_s >= {1'b0, target_s}) begin
              duty_s  = target_s;
              state_s = ST_RUN;
            end else begin
              duty_s = duty_sum_s[PWM_BITS-1:0];
            end
          end else begin
            ramp_cnt_s = ramp_cnt_r + RAMP_ONE;
          end
        end
        ST_RUN: begin
          duty_s = target_s;
        end
        default: begin
          state_s = ST_IDLE;
          duty_s  = '0;
        end
      endcase
    end

    // Bridge is only driven while ramping or running.
    if ((state_s == ST_RAMP) || (state_s == ST_RUN)) begin
      dir_s = dir_pattern(active_cmd_s);
    end else begin
      dir_s = {DIR_COAST, DIR_COAST};
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      active_cmd_r <= CMD_STOP;
      duty_r       <= '0;
      dead_cnt_r   <= '0;
      ramp_cnt_r   <= '0;
      dir_r        <= 4'b0000;
    end else begin
      state_r      <= state_s;
      active_cmd_r <= active_cmd_s;
      duty_r       <= duty_s;
      dead_cnt_r   <= dead_cnt_s;
      ramp_cnt_r   <= ramp_cnt_s;
      dir_r        <= dir_s;
    end
  end

  pwm_gen #(
    .PWM_BITS   (PWM_BITS),
    .PWM_PERIOD (PWM_PERIOD)
  ) u_pwm (
    .clk        (clk),
    .rst_n      (rst_n),
    .duty       (duty_r),
    .force_zero (change_s),
    .pwm_out    (pwm_s)
  );

  assign bus.left_in1   = dir_r[3];
  assign bus.left_in2   = dir_r[2];
  assign bus.right_in1  = dir_r[1];
  assign bus.right_in2  = dir_r[0];
  assign bus.left_en    = pwm_s;
  assign bus.right_en   = pwm_s;
  assign bus.ctrl_state = state_r;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Self-checking bench for motor_drive_ctrl. Two instances share one command
// stream: "a" with a normal forward duty and "b" with forward duty equal to
// the PWM period (constant-high enable in RUN). Timing is scaled down.
module tb_motor_drive_ctrl;
  import motor_pkg::*;

  localparam int PB   = 5;
  localparam int PP   = 20;
  localparam int FD_A = 16;
  localparam int FD_B = 20;
  localparam int TD   = 12;
  localparam int RS   = 3;
  localparam int RD   = 7;
  localparam int DC   = 40;
  localparam int KCAP = 1000000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] driver = 2'b00;

  always #5 clk = ~clk;

  motor_drive_ctrl_if bus_a ();
  motor_drive_ctrl_if bus_b ();
  assign bus_a.driver = driver;
  assign bus_b.driver = driver;

  motor_drive_ctrl #(.PWM_BITS(PB), .PWM_PERIOD(PP), .FWD_DUTY(FD_A), .TURN_DUTY(TD),
                     .RAMP_STEP(RS), .RAMP_DIV(RD), .DEAD_CYCLES(DC))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  motor_drive_ctrl #(.PWM_BITS(PB), .PWM_PERIOD(PP), .FWD_DUTY(FD_B), .TURN_DUTY(TD),
                     .RAMP_STEP(RS), .RAMP_DIV(RD), .DEAD_CYCLES(DC))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  bit startup = 1'b0;
  int en_w0 = 0, en_w1 = 0, en_w2 = 0, enb_w2 = 0;

  // Reference model: the command in force, edges since it was latched,
  // PWM counter and per-instance shadow duty.
  int m_cmd, m_k, m_cnt;
  int m_shadow [2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic int m_target(input int i);
    if (m_cmd == 1) return (i == 0) ? FD_A : FD_B;
    if (m_cmd == 0) return 0;
    return TD;
  endfunction

  // Duty = 0 during coast, else step*ticks-since-coast-ended, capped.
  function automatic int m_duty(input int i);
    int d;
    if (m_cmd == 0 || m_k < DC) return 0;
    d = ((m_k - DC) / RD) * RS;
    return (d < m_target(i)) ? d : m_target(i);
  endfunction

  function automatic int m_state(input int i);
    if (m_k < DC) return 1;
    if (m_cmd == 0) return 0;
    return (m_duty(i) == m_target(i)) ? 3 : 2;
  endfunction

  function automatic int exp_vec(input int i);
    int st, pins, en;
    st = m_state(i);
    pins = 0;
    if (st >= 2) begin
      case (m_cmd)
        1: pins = 4'b1010;
        2: pins = 4'b0110;
        3: pins = 4'b1001;
        default: pins = 0;
      endcase
    end
    en = (m_cnt < m_shadow[i]) ? 1 : 0;
    return (st << 6) | (pins << 2) | (en << 1) | en;
  endfunction

  function automatic int dut_vec(input int i);
    logic [7:0] v;
    if (i == 0)
      v = {bus_a.ctrl_state, bus_a.left_in1, bus_a.left_in2, bus_a.right_in1,
           bus_a.right_in2, bus_a.left_en, bus_a.right_en};
    else
      v = {bus_b.ctrl_state, bus_b.left_in1, bus_b.left_in2, bus_b.right_in1,
           bus_b.right_in2, bus_b.left_en, bus_b.right_en};
    return int'(v);
  endfunction

  task automatic model_reset();
    m_cmd = 0; m_k = KCAP; m_cnt = 0;
    m_shadow[0] = 0; m_shadow[1] = 0;
  endtask

  // Advance the model across one rising edge that saw command d.
  task automatic model_edge(input int d);
    int dprev [2];
    dprev[0] = m_duty(0);
    dprev[1] = m_duty(1);
    m_cnt = (m_cnt + 1) % PP;
    if (d != m_cmd) begin
      m_cmd = d; m_k = 0;
      m_shadow[0] = 0; m_shadow[1] = 0;
    end else begin
      if (m_k < KCAP) m_k++;
      if (m_cnt == 0) begin
        m_shadow[0] = dprev[0];
        m_shadow[1] = dprev[1];
      end
    end
  endtask

  // Hand-computed expectations for the power-up forward run (edges from
  // release): DEAD 1..40, RAMP from 41, ticks at 48,55,62,69,76,83(,90 for b);
  // wraps at 60/80/100 load duty 6/15/16 (b: 6/15/20).
  task automatic startup_checks();
    if (edge_n == 40) chk("startup_dead_end", int'(bus_a.ctrl_state), 1);
    if (edge_n == 41) begin
      chk("startup_ramp_state", int'(bus_a.ctrl_state), 2);
      chk("startup_left_in1", int'(bus_a.left_in1), 1);
      chk("startup_right_in1", int'(bus_a.right_in1), 1);
    end
    if (edge_n == 82) chk("a_ramp_before_run", int'(bus_a.ctrl_state), 2);
    if (edge_n == 83) chk("a_run_entry", int'(bus_a.ctrl_state), 3);
    if (edge_n == 89) chk("b_ramp_before_run", int'(bus_b.ctrl_state), 2);
    if (edge_n == 90) chk("b_run_entry", int'(bus_b.ctrl_state), 3);
    if (edge_n >= 60 && edge_n <= 79) en_w0 += int'(bus_a.left_en);
    if (edge_n >= 80 && edge_n <= 99) en_w1 += int'(bus_a.left_en);
    if (edge_n >= 100 && edge_n <= 119) begin
      en_w2  += int'(bus_a.right_en);
      enb_w2 += int'(bus_b.left_en);
    end
  endtask

  // Per-cycle comparison against the model.
  task automatic run_cycles(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      model_edge(int'(driver));
      edge_n++;
      @(negedge clk);
      chk("dut_a_outputs", dut_vec(0), exp_vec(0));
      chk("dut_b_outputs", dut_vec(1), exp_vec(1));
      if (startup) startup_checks();
    end
  endtask

  initial begin
    int bad;
    int hold;
    model_reset();
    // Reset held with a forward command present.
    driver = 2'b01;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_a", dut_vec(0), 0);
    chk("reset_outputs_b", dut_vec(1), 0);
    rst_n = 1'b1;

    // Power-up forward: full DEAD, ramp, RUN; wrap-only duty updates.
    startup = 1'b1;
    edge_n = 0;
    run_cycles(130);
    startup = 1'b0;
    chk("pwm_window_60_79", en_w0, 6);
    chk("pwm_window_80_99", en_w1, 15);
    chk("pwm_window_100_119", en_w2, 16);
    chk("b_full_duty_const_high", enb_w2, 20);

    // Reversal forward -> left.
    driver = 2'b10;
    run_cycles(1);
    chk("reversal_pins_off", dut_vec(0) & 8'h3f, 0);
    chk("reversal_dead", int'(bus_a.ctrl_state), 1);
    run_cycles(DC);
    chk("reversal_ramp", int'(bus_a.ctrl_state), 2);
    chk("reversal_left_in2", int'(bus_a.left_in2), 1);
    chk("reversal_right_in1", int'(bus_a.right_in1), 1);
    run_cycles(100);
    chk("reversal_run", int'(bus_a.ctrl_state), 3);

    // Right, then stop.
    driver = 2'b11;
    run_cycles(150);
    driver = 2'b00;
    run_cycles(1);
    chk("stop_pins_off", dut_vec(0) & 8'h3f, 0);
    run_cycles(DC);
    chk("stop_idle", int'(bus_a.ctrl_state), 0);
    bad = 0;
    for (int j = 0; j < 200; j++) begin
      run_cycles(1);
      bad += int'(bus_a.left_en | bus_a.right_en | bus_b.left_en);
    end
    chk("stop_en_stays_low", bad, 0);

    // Chatter shorter than the dead time.
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      driver = (t % 2 == 0) ? 2'b01 : 2'b10;
      for (int j = 0; j < 30; j++) begin
        run_cycles(1);
        if (bus_a.ctrl_state != 2'b01 || bus_b.ctrl_state != 2'b01 ||
            bus_a.left_en || bus_a.right_en || bus_b.left_en || bus_b.right_en)
          bad++;
      end
    end
    chk("chatter_stays_dead", bad, 0);

    // Reset in the middle of RUN, then re-entry through a full DEAD.
    driver = 2'b01;
    run_cycles(150);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_a", dut_vec(0), 0);
    chk("async_reset_b", dut_vec(1), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_cycles(DC);
    chk("rereset_dead_full", int'(bus_a.ctrl_state), 1);
    run_cycles(1);
    chk("rereset_ramp", int'(bus_a.ctrl_state), 2);

    // Randomized command stream.
    for (int s = 0; s < 300; s++) begin
      driver = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) hold = $urandom_range(1, DC - 1);
      else hold = $urandom_range(DC, DC + 150);
      run_cycles(hold);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motor_drive_ctrl.md
Name: motor_drive_ctrl

Overview:
- Downstream of the UART/Bluetooth command receiver. Consumes its 2-bit drive command (00 stop, 01 forward, 10 left, 11 right).
- Generates direction pins and PWM enables for the dual H-bridge (L298N-style) driving the left and right wheels.
- Enforces a dead-time on every command change, then soft-start ramps the duty. This protects the bridge and limits inrush.
- Runs on the 50 MHz system clock, the same clock as the receiver.

Parameters:
- PWM_BITS, 10, width of the duty and PWM counter.
- PWM_PERIOD, 1000, PWM period in clk cycles (50 kHz at 50 MHz).
- FWD_DUTY, 800, target duty for forward.
- TURN_DUTY, 600, target duty for both wheels when spinning left or right.
- RAMP_STEP, 8, duty increment per ramp tick.
- RAMP_DIV, 5000, clk cycles per ramp tick.
- DEAD_CYCLES, 50000, coast time after a command change (1 ms).

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- driver  in  2  drive command from the receiver (level, same clock domain)
- left_in1  out  1  left bridge direction A
- left_in2  out  1  left bridge direction B
- right_in1  out  1  right bridge direction A
- right_in2  out  1  right bridge direction B
- left_en  out  1  left bridge PWM enable
- right_en  out  1  right bridge PWM enable
- ctrl_state  out  2  current FSM state, for LEDs and debug

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All state is cleared on assertion and released synchronously to clk.
- Reset values:
  - All direction pins and enables are 0.
  - ctrl_state is IDLE (00).
  - active_cmd is 00; duty and duty_shadow are 0; PWM counter, ramp counter and dead counter are 0.
- Direction encoding, per wheel:
  - Forward: in1=1, in2=0.
  - Reverse: in1=0, in2=1.
  - Coast or brake: in1=0, in2=0.
- Direction per command:
  - Forward (01): both wheels forward.
  - Left (10): left wheel reverse, right wheel forward.
  - Right (11): left wheel forward, right wheel reverse.
  - Stop (00): both wheels coast.
- Target duty: FWD_DUTY for forward, TURN_DUTY for left or right, 0 for stop.
- FSM states: IDLE=00, DEAD=01, RAMP=10, RUN=11.
- Change detection:
  - Applies in any state: driver != active_cmd at a clk edge.
  - On that edge, active_cmd<=driver, duty<=0, duty_shadow<=0, dead counter<=0, state<=DEAD.
  - Consequence: enables and direction pins are 0 from the next cycle (1-cycle latency).
- DEAD:
  - Direction pins and enables are all 0.
  - The counter increments to DEAD_CYCLES-1, then the FSM moves to IDLE if active_cmd==00, else to RAMP with the ramp counter cleared.
  - A new change during DEAD restarts DEAD (counter reset to 0).
- RAMP:
  - Direction pins follow active_cmd.
  - Every RAMP_DIV cycles: duty <= min(duty+RAMP_STEP, target).
  - When duty reaches target, the FSM goes to RUN.
  - The addition is performed PWM_BITS+1 wide, so there is no wrap.
- RUN: duty is held at target. The FSM leaves RUN only on a change.
- IDLE: all outputs are 0. A change to a nonzero command goes to DEAD. A stop command while already stopped is a no-op.
- PWM:
  - The counter runs 0..PWM_PERIOD-1, then wraps to 0.
  - duty_shadow<=duty only on the wrap cycle (glitch-free update). The exception is the forced 0 on a change, which takes effect immediately.
  - en = (pwm_cnt < duty_shadow), the same value for left and right.
  - duty_shadow==0 means the enable is constant 0.
  - duty_shadow >= PWM_PERIOD means the enable is constant 1.
  - The PWM counter free-runs in all states after reset.
- Simultaneous events:
  - A change on the same edge as a ramp tick or a DEAD expiry: the change wins.
  - A change on the PWM wrap edge: the forced 0 wins over the shadow load.
- Reset mid-operation: outputs go to 0 asynchronously. Re-entry after release is via IDLE, so any nonzero driver goes through a full DEAD period.

Decomposition:
- Shared package motor_pkg holds:
  - Command encodings CMD_STOP, CMD_FWD, CMD_LEFT, CMD_RIGHT, shared with the receiver.
  - State encodings ST_IDLE, ST_DEAD, ST_RAMP, ST_RUN.
  - Direction pin pattern constants.
- One sub-module, pwm_gen:
  - Holds the counter, shadow register and compare.
  - Ports: clk, rst_n, duty, force_zero, pwm_out.
  - One instance is shared by both wheels.

Test Plan:
- Reset check: hold rst_n=0 with driver=01. All outputs must be 0 and ctrl_state=00. Release reset: DEAD lasts 50000 cycles, then RAMP with left_in1=1, right_in1=1.
- Forward ramp: 00->01. DEAD for exactly 50000 cycles. Duty rises 8 per 5000 cycles and reaches 800 after 100 ticks. RUN then gives en high for 800 of every 1000 cycles.
- Reversal: in RUN forward, apply 01->10. The cycle after must show all pins 0. After 50000 cycles: left_in2=1, right_in1=1. Duty ramps to 600.
- Stop: in RUN, apply 11->00. Pins are 0 on the next cycle. After DEAD, ctrl_state=IDLE and en stays 0 indefinitely.
- Chatter: toggle driver 01/10 every 20000 cycles. The FSM must never leave DEAD and both enables must never assert.
- PWM boundary: parameterise FWD_DUTY=1000. RUN must give a constant-high en. Separately, check that a duty update lands only on the pwm_cnt wrap.
